safe_clk_rst_seq_ctrl: RTL and testbench

- Safety-island sequencer for the clock/reset monitor datapath; runs on the safety clock.
- Holds the main-domain reset, waits for main clock stability, then releases reset and arms the frequency monitors.
- Debounces monitor error flags and escalates confirmed faults: bounded re-sequence retries, then a latched safe state that only software can clear.

---
 rtl/safe_clk_rst_seq_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_safe_clk_rst_seq_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/safe_clk_rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// safe_clk_rst_seq_ctrl
//
// Safety-island sequencer for the clock/reset monitor datapath. It runs on the
// safety clock and does four things:
//   - holds the main-domain reset low,
//   - waits for the main clock to report stable,
//   - releases the main reset and, after a delay, arms the frequency monitors,
//   - debounces monitor error flags and escalates confirmed faults.
// A confirmed fault re-runs the sequence a bounded number of times. After the
// last retry the block parks in SAFE, and only a software request leaves it.
//
// Ports
//   clk_safety_i        safety-domain clock (the only clock)
//   rst_n_safety_i      asynchronous active-low reset
//   clk_main_stable_i   main-clock stable flag, async, 2-flop synchronized
//   clk_main_error_i    main-clock frequency error, async, 2-flop synchronized
//   clk_safety_error_i  safety-clock frequency error, already in domain
//   sw_recover_req_i    single-cycle software recovery request (SAFE only)
//   rst_n_main_o        main-domain reset request, active-low
//   mon_en_o            frequency-monitor enable
//   safe_state_o        safe state active
//   fault_o             latched terminal fault
//   fault_code_o        cause of last confirmed fault
//                       (1 timeout, 2 stable loss, 3 main err, 4 safety err,
//                        5 both errors)
//   retry_cnt_o         re-sequence attempts consumed
//   state_o             HOLD=0 CLK_WAIT=1 RELEASE=2 RUN=3 DEBOUNCE=4 SAFE=5
// -----------------------------------------------------------------------------
module safe_clk_rst_seq_ctrl #(
  parameter int HOLD_CYCLES      = 64,
  parameter int CLK_WAIT_TIMEOUT = 4096,
  parameter int ARM_DELAY        = 16,
  parameter int DEBOUNCE         = 4,
  parameter int MAX_RETRIES      = 3,
  parameter int CNT_W            = 16
) (
  input  logic                               clk_safety_i,
  input  logic                               rst_n_safety_i,
  input  logic                               clk_main_stable_i,
  input  logic                               clk_main_error_i,
  input  logic                               clk_safety_error_i,
  input  logic                               sw_recover_req_i,
  output logic                               rst_n_main_o,
  output logic                               mon_en_o,
  output logic                               safe_state_o,
  output logic                               fault_o,
  output logic [3:0]                         fault_code_o,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt_o,
  output logic [2:0]                         state_o
);

  localparam int RW   = $clog2(MAX_RETRIES + 1);
  localparam int DB_W = $clog2(DEBOUNCE + 1);

  typedef enum logic [2:0] {
    S_HOLD     = 3'd0,
    S_CLK_WAIT = 3'd1,
    S_RELEASE  = 3'd2,
    S_RUN      = 3'd3,
    S_DEBOUNCE = 3'd4,
    S_SAFE     = 3'd5
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  timer_q;
  logic [DB_W-1:0]   dcnt_q;
  logic [1:0]        stable_sync_q;
  logic [1:0]        merr_sync_q;

  logic              stable_s;
  logic              main_err_s;
  logic              any_err;
  logic              dcnt_last;
  logic [3:0]        err_code;
  logic              fault_req;
  logic [3:0]        fault_cause;

  // Two-flop synchronizers for the main-domain flags
  always_ff @(posedge clk_safety_i or negedge rst_n_safety_i) begin
    if (!rst_n_safety_i) begin
      stable_sync_q <= 2'b00;
      merr_sync_q   <= 2'b00;
    end else begin
      stable_sync_q <= {stable_sync_q[0], clk_main_stable_i};
      merr_sync_q   <= {merr_sync_q[0], clk_main_error_i};
    end
  end

  assign stable_s   = stable_sync_q[1];
  assign main_err_s = merr_sync_q[1];
  assign any_err    = main_err_s | clk_safety_error_i;

  // The debounce count is 0 in RUN, so this same test confirms directly from
  // RUN when DEBOUNCE == 1.
  assign dcnt_last  = (dcnt_q == DB_W'(DEBOUNCE - 1));

  always_comb begin
    err_code = 4'd4;
    if (main_err_s && clk_safety_error_i) err_code = 4'd5;
    else if (main_err_s)                  err_code = 4'd3;
  end

  // Fault detection. Stable loss outranks a debounce confirmation in the same
  // cycle. In CLK_WAIT, stable_s outranks the timeout.
  always_comb begin
    fault_req   = 1'b0;
    fault_cause = 4'd0;
    unique case (state_q)
      S_CLK_WAIT: begin
        if (!stable_s && timer_q == CNT_W'(CLK_WAIT_TIMEOUT - 1)) begin
          fault_req   = 1'b1;
          fault_cause = 4'd1;
        end
      end
      S_RELEASE: begin
        if (!stable_s) begin
          fault_req   = 1'b1;
          fault_cause = 4'd2;
        end
      end
      S_RUN, S_DEBOUNCE: begin
        if (!stable_s) begin
          fault_req   = 1'b1;
          fault_cause = 4'd2;
        end else if (any_err && dcnt_last) begin
          fault_req   = 1'b1;
          fault_cause = err_code;
        end
      end
      default: ;
    endcase
  end

  // Main FSM. Every output is registered and set from the state being entered.
  always_ff @(posedge clk_safety_i or negedge rst_n_safety_i) begin
    if (!rst_n_safety_i) begin
      state_q      <= S_HOLD;
      timer_q      <= '0;
      dcnt_q       <= '0;
      rst_n_main_o <= 1'b0;
      mon_en_o     <= 1'b0;
      safe_state_o <= 1'b0;
      fault_o      <= 1'b0;
      fault_code_o <= 4'd0;
      retry_cnt_o  <= '0;
    end else if (fault_req) begin
      fault_code_o <= fault_cause;
      timer_q      <= '0;
      dcnt_q       <= '0;
      rst_n_main_o <= 1'b0;
      mon_en_o     <= 1'b0;
      if (retry_cnt_o < RW'(MAX_RETRIES)) begin
        retry_cnt_o <= retry_cnt_o + 1'b1;
        state_q     <= S_HOLD;
      end else begin
        state_q      <= S_SAFE;
        safe_state_o <= 1'b1;
        fault_o      <= 1'b1;
      end
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (timer_q == CNT_W'(HOLD_CYCLES - 1)) begin
            timer_q <= '0;
            state_q <= S_CLK_WAIT;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_CLK_WAIT: begin
          if (stable_s) begin
            timer_q      <= '0;
            state_q      <= S_RELEASE;
            rst_n_main_o <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_RELEASE: begin
          if (timer_q == CNT_W'(ARM_DELAY - 1)) begin
            timer_q  <= '0;
            state_q  <= S_RUN;
            mon_en_o <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_RUN: begin
          if (any_err) begin
            dcnt_q  <= DB_W'(1);
            state_q <= S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: begin
          if (any_err) begin
            dcnt_q <= dcnt_q + 1'b1;
          end else begin
            dcnt_q  <= '0;
            state_q <= S_RUN;
          end
        end
        S_SAFE: begin
          if (sw_recover_req_i) begin
            state_q      <= S_HOLD;
            timer_q      <= '0;
            retry_cnt_o  <= '0;
            fault_code_o <= 4'd0;
            fault_o      <= 1'b0;
            safe_state_o <= 1'b0;
          end
        end
        default: begin
          state_q      <= S_HOLD;
          timer_q      <= '0;
          dcnt_q       <= '0;
          rst_n_main_o <= 1'b0;
          mon_en_o     <= 1'b0;
        end
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_safe_clk_rst_seq_ctrl.sv
module tb_safe_clk_rst_seq_ctrl;

  localparam int HOLD = 64;
  localparam int TO   = 4096;
  localparam int ARM  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stable_i = 1'b0;
  logic       merr = 1'b0;
  logic       serr = 1'b0;
  logic       swr = 1'b0;
  logic       rst_n_main, mon_en, safe_st, flt;
  logic [3:0] code;
  logic [1:0] retry;
  logic [2:0] st;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0] st;
    logic       rst_n_main;
    logic       mon;
    logic       safe;
    logic       flt;
    logic [3:0] code;
    logic [1:0] retry;
  } snap_t;

  snap_t expq[$];
  string tagq[$];

  safe_clk_rst_seq_ctrl #(
    .HOLD_CYCLES(HOLD), .CLK_WAIT_TIMEOUT(TO), .ARM_DELAY(ARM),
    .DEBOUNCE(4), .MAX_RETRIES(3), .CNT_W(16)
  ) dut (
    .clk_safety_i      (clk),
    .rst_n_safety_i    (rst_n),
    .clk_main_stable_i (stable_i),
    .clk_main_error_i  (merr),
    .clk_safety_error_i(serr),
    .sw_recover_req_i  (swr),
    .rst_n_main_o      (rst_n_main),
    .mon_en_o          (mon_en),
    .safe_state_o      (safe_st),
    .fault_o           (flt),
    .fault_code_o      (code),
    .retry_cnt_o       (retry),
    .state_o           (st)
  );

  always #5 clk = ~clk;

  function automatic snap_t mk(input logic [2:0] s, input logic r, input logic m,
                               input logic sf, input logic f, input logic [3:0] c,
                               input logic [1:0] rt);
    snap_t e;
    e = '{st: s, rst_n_main: r, mon: m, safe: sf, flt: f, code: c, retry: rt};
    return e;
  endfunction

  task automatic push(input string tag, input snap_t e);
    tagq.push_back(tag);
    expq.push_back(e);
  endtask

  task automatic pop_check();
    snap_t e, o;
    string t;
    e = expq.pop_front();
    t = tagq.pop_front();
    o = '{st: st, rst_n_main: rst_n_main, mon: mon_en, safe: safe_st,
          flt: flt, code: code, retry: retry};
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s: observed st=%0d rstm=%b mon=%b safe=%b flt=%b code=%0d retry=%0d expected st=%0d rstm=%b mon=%b safe=%b flt=%b code=%0d retry=%0d",
             t, o.st, o.rst_n_main, o.mon, o.safe, o.flt, o.code, o.retry,
             e.st, e.rst_n_main, e.mon, e.safe, e.flt, e.code, e.retry);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bounded wait for a state; an expired budget is a failed comparison.
  task automatic wait_state(input logic [2:0] s, input int budget, output int n);
    n = 0;
    while (st !== s && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    assert (st === s) else begin
      failures++;
      $error("FAIL wait_state: observed state %0d expected %0d within %0d cycles", st, s, budget);
    end
  endtask

  initial begin
    int n, n2;
    rst_n = 1'b0;
    stable_i = 1'b1;
    #12;
    push("reset_values", mk(0, 0, 0, 0, 0, 0, 0));
    pop_check();

    // Nominal bring-up
    @(posedge clk); #1;
    rst_n = 1'b1;
    push("nominal_run", mk(3, 1, 1, 0, 0, 0, 0));
    wait_state(3'd2, 200, n);
    chk_int("rst_release_cycles", n, HOLD + 1);
    wait_state(3'd3, 100, n);
    chk_int("arm_cycles", n, ARM);
    pop_check();

    // Recovery request outside SAFE is ignored
    swr = 1'b1; tick(1); swr = 1'b0; tick(3);
    push("recover_in_run_ignored", mk(3, 1, 1, 0, 0, 0, 0));
    pop_check();

    // Debounce reject: 3-cycle safety error pulse
    serr = 1'b1; tick(1);
    push("debounce_enter", mk(4, 1, 1, 0, 0, 0, 0));
    pop_check();
    tick(2); serr = 1'b0; tick(1);
    push("debounce_reject", mk(3, 1, 1, 0, 0, 0, 0));
    pop_check();
    tick(2);

    // Debounce confirm: 4-cycle safety error pulse
    serr = 1'b1; tick(3);
    push("debounce_pre_confirm", mk(4, 1, 1, 0, 0, 0, 0));
    pop_check();
    tick(1); serr = 1'b0;
    push("safety_fault", mk(0, 0, 0, 0, 0, 4, 1));
    pop_check();

    push("rerun_1", mk(3, 1, 1, 0, 0, 4, 1));
    wait_state(3'd3, 200, n);
    chk_int("resequence_cycles", n, HOLD + 1 + ARM);
    pop_check();

    // Both errors: main error arrives through the synchronizer 2 cycles late
    merr = 1'b1; serr = 1'b1; tick(4); merr = 1'b0; serr = 1'b0;
    push("both_errors", mk(0, 0, 0, 0, 0, 5, 2));
    pop_check();
    push("rerun_2", mk(3, 1, 1, 0, 0, 5, 2));
    wait_state(3'd3, 200, n);
    pop_check();

    // Stable loss while debouncing wins immediately with code 2
    stable_i = 1'b0; serr = 1'b1; tick(2);
    push("stable_loss_in_debounce", mk(4, 1, 1, 0, 0, 5, 2));
    pop_check();
    tick(1);
    push("stable_loss_fault", mk(0, 0, 0, 0, 0, 2, 3));
    pop_check();
    stable_i = 1'b1; serr = 1'b0;
    push("rerun_3", mk(3, 1, 1, 0, 0, 2, 3));
    wait_state(3'd3, 200, n);
    pop_check();

    // Retries exhausted -> SAFE, retry count saturates
    serr = 1'b1; tick(4); serr = 1'b0;
    push("saturate_safe", mk(5, 0, 0, 1, 1, 4, 3));
    pop_check();

    // SAFE ignores every monitor input
    for (int i = 0; i < 20; i++) begin
      merr = i[0]; serr = i[1]; stable_i = i[2];
      tick(1);
    end
    merr = 1'b0; serr = 1'b0; stable_i = 1'b0;
    tick(3);
    push("safe_holds", mk(5, 0, 0, 1, 1, 4, 3));
    pop_check();

    // Software recovery; stable stays low so every sequence times out
    swr = 1'b1; tick(1); swr = 1'b0;
    push("recovered", mk(0, 0, 0, 0, 0, 0, 0));
    pop_check();
    for (int k = 1; k <= 3; k++) begin
      wait_state(3'd1, 100, n);
      wait_state(3'd0, TO + 100, n2);
      chk_int("timeout_cycles", n + n2, HOLD + TO);
      push("timeout_fault", mk(0, 0, 0, 0, 0, 1, k[1:0]));
      pop_check();
    end
    wait_state(3'd1, 100, n);
    wait_state(3'd5, TO + 100, n2);
    chk_int("timeout_cycles_last", n + n2, HOLD + TO);
    push("timeout_safe", mk(5, 0, 0, 1, 1, 1, 3));
    pop_check();

    // Asynchronous reset from SAFE
    #3; rst_n = 1'b0; #1;
    push("async_reset_in_safe", mk(0, 0, 0, 0, 0, 0, 0));
    pop_check();
    stable_i = 1'b1;
    tick(2);
    rst_n = 1'b1;
    wait_state(3'd2, 200, n);
    chk_int("rst_release_after_safe", n, HOLD + 1);

    // Asynchronous reset from RELEASE, then full nominal restart
    tick(5);
    #3; rst_n = 1'b0; #1;
    push("async_reset_in_release", mk(0, 0, 0, 0, 0, 0, 0));
    pop_check();
    tick(1);
    rst_n = 1'b1;
    push("nominal_restart", mk(3, 1, 1, 0, 0, 0, 0));
    wait_state(3'd2, 200, n);
    chk_int("rst_release_restart", n, HOLD + 1);
    wait_state(3'd3, 100, n);
    chk_int("arm_cycles_restart", n, ARM);
    pop_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
